// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: 8x8 matrix row scanner with a double-buffered frame handshake.
// Ports: clk, rst (async, active-high); enable runs the scan; frame_in/frame_valid/
// frame_ready load the pending buffer; row_sel/col_data drive the matrix (registered);
// frame_done pulses on the first blank cycle of row 0 after row 7.
module matrix_scan_driver #(
   parameter int CLK_DIV      = 1000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [63:0] frame_in,
   input  logic        frame_valid,
   output logic        frame_ready,
   output logic [7:0]  row_sel,
   output logic [7:0]  col_data,
   output logic        frame_done
);
   localparam int MAXC = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    row_q, row_d;
   logic [63:0]   active_q, active_d, pending_q, pending_d;
   logic          pend_full_q, pend_full_d;
   logic          frame_ready_q, frame_done_q, frame_done_d;
   logic [7:0]    row_sel_q, row_sel_d, col_data_q, col_data_d;
   logic          accept, blank_end, on_end, frame_end;
   always_comb begin
      accept      = frame_valid && frame_ready_q;
      blank_end   = cnt_q == CW'(BLANK_CYCLES - 1);
      on_end      = cnt_q == CW'(CLK_DIV - 1);
      frame_end   = enable && state_q == ON && on_end && row_q == 3'd7;
      state_d     = !enable ? IDLE :
                    state_q == IDLE ? BLANK :
                    state_q == BLANK ? (blank_end ? ON : BLANK) :
                    (on_end ? BLANK : ON);
      cnt_d       = (state_d != state_q || state_d == IDLE) ? '0 : cnt_q + 1'b1;
      row_d       = (!enable || state_q == IDLE) ? 3'd0 :
                    (state_q == ON && on_end) ? row_q + 3'd1 : row_q;
      // Swap only at the frame boundary, so a frame never tears mid-scan.
      active_d    = (frame_end && pend_full_q) ? pending_q : active_q;
      pending_d   = accept ? frame_in : pending_q;
      // accept needs pending empty and the swap needs it full, so they never coincide.
      pend_full_d = accept || (pend_full_q && !frame_end);
      frame_done_d = frame_end;
      // Outputs are computed from the next state so they line up with state entry.
      row_sel_d   = (state_d == ON) ? 8'h01 << row_d : 8'h00;
      col_data_d  = (state_d == ON) ? active_q[{row_d, 3'b000} +: 8] : 8'h00;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         row_q         <= 3'd0;
         active_q      <= '0;
         pending_q     <= '0;
         pend_full_q   <= 1'b0;
         frame_ready_q <= 1'b1;
         frame_done_q  <= 1'b0;
         row_sel_q     <= 8'h00;
         col_data_q    <= 8'h00;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         row_q         <= row_d;
         active_q      <= active_d;
         pending_q     <= pending_d;
         pend_full_q   <= pend_full_d;
         frame_ready_q <= !pend_full_d;
         frame_done_q  <= frame_done_d;
         row_sel_q     <= row_sel_d;
         col_data_q    <= col_data_d;
      end
   end
   assign frame_ready = frame_ready_q;
   assign frame_done  = frame_done_q;
   assign row_sel     = row_sel_q;
   assign col_data    = col_data_q;
endmodule
